// File: rtl/counter_pwm_pkg.sv
// Shared types and constants for the counter PWM compare block.
// Imported by the top and the per-channel compare stage.
package counter_pwm_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef logic [CNT_W-1:0] duty_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty handshake, shadow/active duty,
// registered pwm output and match strobe.
module pwm_channel
  import counter_pwm_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] count_q,
  input  logic             wrap,
  input  logic             enable,
  input  logic             duty_valid,
  input  logic [WIDTH-1:0] duty_data,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             match_pulse,
  output logic             match_next
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] active_next;
  logic             pending;
  logic             xfer;
  logic             load;
  logic             pwm_next;

  assign xfer        = wrap & pending;
  assign load        = duty_valid & duty_ready;
  assign duty_ready  = ~pending & ~reset;

  // Compare against the duty that will be active this cycle,
  // so a new duty governs count 0 of the new period.
  assign active_next = xfer ? shadow : active;

  assign pwm_next    = enable & (count < active_next);
  assign match_next  = enable & (count == active_next)
                     & (count != count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      pwm_out     <= pwm_next;
      match_pulse <= match_next;
      // load and xfer are exclusive: load needs
      // pending low, xfer needs it high.
      if (xfer) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= duty_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_pwm_compare.sv
// PWM compare stage fed by the free-running counter bus:
// wrap detection, wrap strobe, sticky irq and channel array.
module counter_pwm_compare
  import counter_pwm_pkg::*;
#(
  parameter int WIDTH  = CNT_W,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        count,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       duty_valid,
  input  logic [NUM_CH*WIDTH-1:0] duty_data,
  output logic [NUM_CH-1:0]       duty_ready,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       match_pulse,
  output logic                    wrap_pulse,
  output logic                    irq,
  input  logic                    irq_clr
);

  logic [WIDTH-1:0]  count_q;
  logic              wrap;
  logic              wrap_next;
  logic [NUM_CH-1:0] match_next;

  // Any decrease is a wrap, so skipped codes still wrap.
  assign wrap      = count < count_q;
  assign wrap_next = enable & wrap;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .count      (count),
      .count_q    (count_q),
      .wrap       (wrap),
      .enable     (enable),
      .duty_valid (duty_valid[i]),
      .duty_data  (duty_data[i*WIDTH +: WIDTH]),
      .duty_ready (duty_ready[i]),
      .pwm_out    (pwm_out[i]),
      .match_pulse(match_pulse[i]),
      .match_next (match_next[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wrap_pulse <= 1'b0;
      irq        <= 1'b0;
    end else begin
      count_q    <= count;
      wrap_pulse <= wrap_next;
      // A new strobe beats a simultaneous clear.
      if (|match_next | wrap_next)
        irq <= 1'b1;
      else if (irq_clr)
        irq <= 1'b0;
    end
  end

endmodule
